md_exec_seq: RTL and testbench
==============================

Name: md_exec_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide instructions that sit in the Execute stage beside the single-cycle ALU.
- Accepts an M-extension op from Execute and iterates a shift-add multiplier / restoring divider for XLEN cycles.
- Stalls the F/D/E pipeline while busy, then presents a one-cycle result that the Execute pipeline register captures as the ALU output would be.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 5, width of the iteration counter, equal to clog2(XLEN).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mdStartE  input  1  Execute holds a valid M-extension op
- mdOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- r1E  input  XLEN  rs1 operand (dividend / multiplicand)
- r2E  input  XLEN  rs2 operand (divisor / multiplier)
- flushE  input  1  Execute-stage flush (branch taken ahead)
- mdStallE  output  1  hold Fetch/Decode/Execute pipeline registers
- mdDoneE  output  1  result valid this cycle
- mdResultE  output  XLEN  result, held until the next start

Behaviour:
- Reset: state IDLE; mdStallE=0, mdDoneE=0, mdResultE=0; counter, accumulator and operand registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - mdStallE = mdStartE & ~flushE (combinational).
  - On a sampled start without flush: latch the op and absolute operands; record sign flags per op; load counter = XLEN-1.
  - Go to CALC, or to DONE if a special case applies.
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - All other ops: unsigned.
- CALC:
  - One iteration per cycle; counter decrements.
  - At counter 0, go to FIX.
  - Multiply builds the 2*XLEN product; divide produces quotient and remainder.
- FIX:
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the output: MUL gives product[XLEN-1:0]; MULH* gives product[2XLEN-1:XLEN]; DIV* gives quotient; REM* gives remainder.
  - Register mdResultE; go to DONE.
- DONE:
  - mdDoneE=1, mdStallE=0, so Execute advances and captures the result.
  - mdStartE is ignored this cycle because the same instruction is still present.
  - Return to IDLE.
- mdStallE is 1 throughout CALC and FIX.
- Latency, normal op: start sampled in cycle t; CALC runs t+1..t+XLEN; FIX at t+XLEN+1; DONE at t+XLEN+2 (t+34 for XLEN=32). Total stall is 34 cycles.
- Special cases, detected in IDLE; next state DONE, result valid at t+1:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
  - Multiply with a zero operand is not special-cased.
- Flush:
  - flushE in CALC or FIX: abort to IDLE next cycle; no mdDoneE; mdResultE unchanged.
  - flushE in DONE: mdDoneE still pulses; the Execute register flush discards the result.
- Reset mid-operation: return to IDLE immediately; all outputs are at reset values.
- Back-to-back M ops: the new instruction enters Execute the cycle after DONE; IDLE samples it there (one bubble-free handoff).
- Arithmetic: unsigned 2*XLEN accumulator; negation is two's complement modulo 2^XLEN (or 2^(2XLEN) for the product).

Decomposition:
- Shared package (rv_pkg) holds: MD_* funct3 localparams; state encoding (IDLE=0, CALC=1, FIX=2, DONE=3); XLEN.
- One sub-module, md_iter_dp, holds the iterative datapath:
  - Accumulator, operand shift registers, and one-step add/subtract.
  - Controlled by init/step signals from the FSM.
  - Reports product, quotient and remainder.
- The FSM, special-case detection, sign handling and result selection stay in md_exec_seq.

Test Plan:
- MUL 7 × -3 (r2=0xFFFFFFFD): stall 34 cycles; mdDoneE at t+34; result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF × 2 gives 0xFFFFFFFF.
- DIV -7 / 2 gives 0xFFFFFFFD. REM -7 / 2 gives 0xFFFFFFFF. DIVU 100 / 7 gives 14. REMU 100 / 7 gives 2.
- DIV 5 / 0 gives 0xFFFFFFFF with done at t+1. REMU 5 / 0 gives 5. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000. REM of the same gives 0.
- Start DIVU, flushE at CALC cycle 10: IDLE next cycle; no done; mdStallE=0; mdResultE keeps the prior value. Then start MUL 3 × 4: result 12 at t+34.
- Assert rst in CALC cycle 5: immediate IDLE with outputs 0. Separately, two consecutive MUL instructions: the second starts the cycle after DONE, and both results are correct with no spurious done.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: operand width,
// funct3 encodings of the multiply/divide ops and the sequencer state encoding.
// Ports: none (package).
package rv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   // funct3 encodings; bit 2 separates divide/remainder from multiply
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdState_t;

endpackage

// File: rtl/md_iter_dp.sv
// Iterative unsigned datapath: one shift-add multiply or restoring divide step per cycle.
// Ports: clk/rst; init loads opA/opB and the mode, step advances one iteration;
//        product, quotient and remainder are views of the shared accumulator.
module md_iter_dp #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              step,
   input  logic              isDiv,
   input  logic [XLEN-1:0]   opA,
   input  logic [XLEN-1:0]   opB,
   output logic [2*XLEN-1:0] product,
   output logic [XLEN-1:0]   quotient,
   output logic [XLEN-1:0]   remainder
);

   // acc high half: partial product / partial remainder
   // acc low half : multiplier bits still to consume / dividend bits turning into quotient
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opBReg;
   logic              isDivReg;

   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic [XLEN:0]     mulSum;
   logic [2*XLEN-1:0] mulNext;
   logic [XLEN:0]     divShift;
   logic [XLEN:0]     divDiff;
   logic              divGe;
   logic [2*XLEN-1:0] divNext;

   assign hi = acc[2*XLEN-1:XLEN];
   assign lo = acc[XLEN-1:0];

   // Multiply: add multiplicand when the current multiplier bit is set, then shift
   // the whole accumulator right, carry included.
   assign mulSum  = {1'b0, hi} + (lo[0] ? {1'b0, opBReg} : {(XLEN+1){1'b0}});
   assign mulNext = {mulSum, lo[XLEN-1:1]};

   // Divide: bring the next dividend bit into the partial remainder and trial-subtract.
   // The partial remainder is always below the divisor, so bit XLEN of the difference
   // is set only when the subtraction underflows.
   assign divShift = {hi, lo[XLEN-1]};
   assign divDiff  = divShift - {1'b0, opBReg};
   assign divGe    = ~divDiff[XLEN];
   assign divNext  = {(divGe ? divDiff[XLEN-1:0] : divShift[XLEN-1:0]), lo[XLEN-2:0], divGe};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         opBReg   <= '0;
         isDivReg <= 1'b0;
      end else if (init) begin
         acc      <= {{XLEN{1'b0}}, opA};
         opBReg   <= opB;
         isDivReg <= isDiv;
      end else if (step) begin
         acc <= isDivReg ? divNext : mulNext;
      end
   end

   assign product   = acc;
   assign quotient  = acc[XLEN-1:0];
   assign remainder = acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/md_exec_seq.sv
// RV32M multiply/divide sequencer beside the Execute ALU: stalls F/D/E while it
// iterates, then presents the result for one cycle with mdDoneE.
// Ports: clk/rst; mdStartE/mdOpE/r1E/r2E op from Execute; flushE aborts;
//        mdStallE pipeline hold; mdDoneE result strobe; mdResultE held result.
module md_exec_seq #(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int CNT_W = rv_pkg::CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mdStartE,
   input  logic [2:0]      mdOpE,
   input  logic [XLEN-1:0] r1E,
   input  logic [XLEN-1:0] r2E,
   input  logic            flushE,
   output logic            mdStallE,
   output logic            mdDoneE,
   output logic [XLEN-1:0] mdResultE
);

   import rv_pkg::*;

   mdState_t          state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        opReg;
   logic              negQ;     // product / quotient needs negation
   logic              negRem;   // remainder takes the dividend's sign

   logic              accept;
   logic              step;
   logic              aSigned;
   logic              bSigned;
   logic              aNeg;
   logic              bNeg;
   logic [XLEN-1:0]   aAbs;
   logic [XLEN-1:0]   bAbs;
   logic              divZero;
   logic              divOvf;
   logic [XLEN-1:0]   specialRes;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   quotient;
   logic [XLEN-1:0]   remainder;
   logic [2*XLEN-1:0] prodFix;
   logic [XLEN-1:0]   fixRes;

   assign accept = (state == IDLE) && mdStartE && !flushE;
   assign step   = (state == CALC) && !flushE;

   // Stall covers the accepting IDLE cycle combinationally so the op is held
   // in Execute from the cycle it first appears.
   assign mdStallE = accept || (state == CALC) || (state == FIX);

   assign aSigned = (mdOpE == MD_MULH) || (mdOpE == MD_MULHSU) ||
                    (mdOpE == MD_DIV)  || (mdOpE == MD_REM);
   assign bSigned = (mdOpE == MD_MULH) || (mdOpE == MD_DIV) || (mdOpE == MD_REM);
   assign aNeg    = aSigned && r1E[XLEN-1];
   assign bNeg    = bSigned && r2E[XLEN-1];
   assign aAbs    = aNeg ? -r1E : r1E;
   assign bAbs    = bNeg ? -r2E : r2E;

   assign divZero = mdOpE[2] && (r2E == '0);
   assign divOvf  = ((mdOpE == MD_DIV) || (mdOpE == MD_REM)) &&
                    (r1E == {1'b1, {(XLEN-1){1'b0}}}) && (r2E == '1);

   // mdOpE[1] marks the remainder ops among the divides
   always_comb begin
      specialRes = '0;
      if (divZero) begin
         specialRes = mdOpE[1] ? r1E : '1;
      end else if (divOvf) begin
         specialRes = mdOpE[1] ? '0 : r1E;
      end
   end

   md_iter_dp #(
      .XLEN (XLEN)
   ) uIterDp (
      .clk       (clk),
      .rst       (rst),
      .init      (accept),
      .step      (step),
      .isDiv     (mdOpE[2]),
      .opA       (aAbs),
      .opB       (bAbs),
      .product   (product),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_comb begin
      prodFix = negQ ? -product : product;
      fixRes  = '0;
      case (opReg)
         MD_MUL:                        fixRes = prodFix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  fixRes = prodFix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               fixRes = negQ ? -quotient : quotient;
         default:                       fixRes = negRem ? -remainder : remainder;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         opReg     <= '0;
         negQ      <= 1'b0;
         negRem    <= 1'b0;
         mdDoneE   <= 1'b0;
         mdResultE <= '0;
      end else begin
         mdDoneE <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  opReg  <= mdOpE;
                  negQ   <= aNeg ^ bNeg;
                  negRem <= aNeg;
                  cnt    <= CNT_W'(XLEN - 1);
                  if (divZero || divOvf) begin
                     mdResultE <= specialRes;
                     mdDoneE   <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (flushE) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               if (flushE) begin
                  state <= IDLE;
               end else begin
                  mdResultE <= fixRes;
                  mdDoneE   <= 1'b1;
                  state     <= DONE;
               end
            end
            // The same instruction still sits in Execute here, so mdStartE is ignored.
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_exec_seq.sv
module tb_md_exec_seq;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        mdStartE;
   logic [2:0]  mdOpE;
   logic [31:0] r1E;
   logic [31:0] r2E;
   logic        flushE;
   logic        mdStallE;
   logic        mdDoneE;
   logic [31:0] mdResultE;

   int testsRun    = 0;
   int testsFailed = 0;

   md_exec_seq dut (
      .clk       (clk),
      .rst       (rst),
      .mdStartE  (mdStartE),
      .mdOpE     (mdOpE),
      .r1E       (r1E),
      .r2E       (r2E),
      .flushE    (flushE),
      .mdStallE  (mdStallE),
      .mdDoneE   (mdDoneE),
      .mdResultE (mdResultE)
   );

   always #5 clk = ~clk;

   task automatic driveOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      mdOpE    = op;
      r1E      = a;
      r2E      = b;
      mdStartE = 1'b1;
   endtask

   // Presents an op while IDLE, holds it like a stalled Execute stage until done,
   // then retires it at the edge after DONE.
   task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int expLat, input logic [31:0] expRes);
      int cyc;
      bit seenDone;
      bit stallBad;
      driveOp(op, a, b);
      #1;
      testsRun++;
      if (mdStallE !== 1'b1) begin
         testsFailed++;
         $display("FAIL %s stall_at_start got %b want 1", name, mdStallE);
      end
      @(posedge clk);
      cyc      = 0;
      seenDone = 0;
      stallBad = 0;
      while (!seenDone && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (mdDoneE === 1'b1) seenDone = 1;
         else if (mdStallE !== 1'b1) stallBad = 1;
      end
      testsRun++;
      if (!seenDone) begin
         testsFailed++;
         $display("FAIL %s timeout got no done within %0d cycles want done", name, cyc);
      end
      testsRun++;
      if (cyc != expLat) begin
         testsFailed++;
         $display("FAIL %s latency got %0d want %0d", name, cyc, expLat);
      end
      testsRun++;
      if (mdResultE !== expRes) begin
         testsFailed++;
         $display("FAIL %s result got %h want %h", name, mdResultE, expRes);
      end
      testsRun++;
      if (mdStallE !== 1'b0) begin
         testsFailed++;
         $display("FAIL %s stall_in_done got %b want 0", name, mdStallE);
      end
      testsRun++;
      if (stallBad) begin
         testsFailed++;
         $display("FAIL %s stall_gap got gap want continuous stall", name);
      end
      @(posedge clk);
      #1;
      mdStartE = 1'b0;
      testsRun++;
      if (mdDoneE !== 1'b0) begin
         testsFailed++;
         $display("FAIL %s done_pulse got %b after done want 0", name, mdDoneE);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      mdStartE = 1'b0;
      flushE   = 1'b0;
      mdOpE    = 3'b000;
      r1E      = '0;
      r2E      = '0;
      repeat (2) @(negedge clk);
      testsRun++;
      if (mdStallE !== 1'b0) begin
         testsFailed++;
         $display("FAIL reset_stall got %b want 0", mdStallE);
      end
      testsRun++;
      if (mdDoneE !== 1'b0) begin
         testsFailed++;
         $display("FAIL reset_done got %b want 0", mdDoneE);
      end
      testsRun++;
      if (mdResultE !== 32'h0) begin
         testsFailed++;
         $display("FAIL reset_result got %h want 0", mdResultE);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_multiply();
      runOp("mul_7_x_m3",      OP_MUL,    32'd7,        32'hFFFFFFFD, 34, 32'hFFFFFFEB);
      runOp("mulhu_max",       OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE);
      runOp("mulh_min",        OP_MULH,   32'h80000000, 32'h80000000, 34, 32'h40000000);
      runOp("mulhsu_m1_x_2",   OP_MULHSU, 32'hFFFFFFFF, 32'd2,        34, 32'hFFFFFFFF);
   endtask

   task automatic test_divide();
      runOp("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD);
      runOp("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF);
      runOp("divu_100_7", OP_DIVU, 32'd100,      32'd7, 34, 32'd14);
      runOp("remu_100_7", OP_REMU, 32'd100,      32'd7, 34, 32'd2);
   endtask

   task automatic test_special();
      runOp("div_by_zero",  OP_DIV,  32'd5,        32'd0,        1, 32'hFFFFFFFF);
      runOp("div_overflow", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
      runOp("rem_overflow", OP_REM,  32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000);
      runOp("remu_by_zero", OP_REMU, 32'd5,        32'd0,        1, 32'd5);
   endtask

   // Previous result is 5 (REMU 5/0); the aborted divide must leave it alone.
   task automatic test_flush();
      bit sawDone;
      @(negedge clk);
      driveOp(OP_DIVU, 32'd1000, 32'd3);
      @(posedge clk);
      repeat (10) @(negedge clk);
      flushE = 1'b1;
      @(posedge clk);
      #1;
      flushE   = 1'b0;
      mdStartE = 1'b0;
      #1;
      testsRun++;
      if (mdStallE !== 1'b0) begin
         testsFailed++;
         $display("FAIL flush_stall got %b want 0", mdStallE);
      end
      testsRun++;
      if (mdResultE !== 32'd5) begin
         testsFailed++;
         $display("FAIL flush_result got %h want 00000005", mdResultE);
      end
      sawDone = 0;
      repeat (40) begin
         @(negedge clk);
         if (mdDoneE !== 1'b0 || mdStallE !== 1'b0) sawDone = 1;
      end
      testsRun++;
      if (sawDone) begin
         testsFailed++;
         $display("FAIL flush_no_done got activity after abort want idle");
      end
      runOp("flush_then_mul", OP_MUL, 32'd3, 32'd4, 34, 32'd12);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      driveOp(OP_MUL, 32'd9, 32'd9);
      @(posedge clk);
      repeat (5) @(negedge clk);
      #1;
      rst      = 1'b1;
      mdStartE = 1'b0;
      #1;
      testsRun++;
      if (mdStallE !== 1'b0 || mdDoneE !== 1'b0) begin
         testsFailed++;
         $display("FAIL rst_mid_ctrl got stall=%b done=%b want 0 0", mdStallE, mdDoneE);
      end
      testsRun++;
      if (mdResultE !== 32'h0) begin
         testsFailed++;
         $display("FAIL rst_mid_result got %h want 0", mdResultE);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      runOp("after_rst_mul", OP_MUL, 32'd5, 32'd5, 34, 32'd25);
   endtask

   // Second op is presented right after the first retires, with no idle gap.
   task automatic test_back_to_back();
      @(negedge clk);
      runOp("b2b_first",  OP_MUL,   32'd6,       32'd7,      34, 32'd42);
      runOp("b2b_second", OP_MUL,   32'h00012345, 32'h100,   34, 32'h01234500);
      runOp("b2b_third",  OP_DIVU,  32'd0,       32'd0,      1,  32'hFFFFFFFF);
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_special();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
